pipelined_adder_core: RTL and testbench

//  Parametrised, pipelined add/subtract engine for the HPS-driven arithmetic datapath.

---
 rtl/adder_pkg.sv | 28 ++
 rtl/adder_slice.sv | 57 +++++
 rtl/pipelined_adder_core.sv | 104 ++++++++++
 tb/tb_pipelined_adder_core.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared op encodings and elaboration helpers for the pipelined add/subtract core.
package adder_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SADD = 2'b10;
    localparam logic [1:0] OP_SSUB = 2'b11;

    // Upper bound on DATA_W supported by sat_value.
    localparam int unsigned SAT_MAX_W = 1024;

    function automatic int unsigned num_stages(input int unsigned data_w, input int unsigned chunk_w);
        return data_w / chunk_w;
    endfunction

    // Signed saturation limit of a width-bit value: neg=1 -> 100..0, neg=0 -> 011..1.
    function automatic logic [SAT_MAX_W-1:0] sat_value(input logic neg, input int unsigned width);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
            if (i < width) begin
                v[i] = (i == width - 1) ? neg : ~neg;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One pipeline stage: adds chunk IDX of A and B' with the incoming carry and registers the beat.
module adder_slice #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CHUNK_W = 16,
    parameter int unsigned IDX     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              prev_valid,
    input  logic [DATA_W-1:0] prev_a,
    input  logic [DATA_W-1:0] prev_b,
    input  logic [DATA_W-1:0] prev_sum,
    input  logic              prev_carry,
    input  logic [1:0]        prev_op,
    output logic              valid,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              carry,
    output logic [1:0]        op
);

    logic [CHUNK_W:0]   chunk_sum;
    logic [DATA_W-1:0]  merged;

    always_comb begin
        chunk_sum = {1'b0, prev_a[IDX*CHUNK_W +: CHUNK_W]}
                  + {1'b0, prev_b[IDX*CHUNK_W +: CHUNK_W]}
                  + (CHUNK_W+1)'(prev_carry);
        merged = prev_sum;
        merged[IDX*CHUNK_W +: CHUNK_W] = chunk_sum[CHUNK_W-1:0];
    end

    // load is asserted whenever this register is empty or its beat moves on;
    // when load is low the held beat simply stays.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            a     <= '0;
            b     <= '0;
            sum   <= '0;
            carry <= 1'b0;
            op    <= '0;
        end else if (load) begin
            valid <= prev_valid;
            if (prev_valid) begin
                a     <= prev_a;
                b     <= prev_b;
                sum   <= merged;
                carry <= chunk_sum[CHUNK_W];
                op    <= prev_op;
            end
        end
    end

endmodule

// File: rtl/pipelined_adder_core.sv
// Pipelined add/subtract engine with signed saturation, carry/overflow/zero flags and
// a bubble-collapsing valid/ready chain, one CHUNK_W carry slice per stage.
module pipelined_adder_core
    import adder_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CHUNK_W = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_carry,
    output logic              out_ovf,
    output logic              out_zero,
    output logic [CNT_W-1:0]  op_count,
    output logic              busy
);

    localparam int unsigned NS = num_stages(DATA_W, CHUNK_W);
    localparam int unsigned L  = NS - 1;

    localparam logic [SAT_MAX_W-1:0] SAT_POS_FULL = sat_value(1'b0, DATA_W);
    localparam logic [SAT_MAX_W-1:0] SAT_NEG_FULL = sat_value(1'b1, DATA_W);
    localparam logic [DATA_W-1:0]    SAT_POS      = SAT_POS_FULL[DATA_W-1:0];
    localparam logic [DATA_W-1:0]    SAT_NEG      = SAT_NEG_FULL[DATA_W-1:0];

    logic [NS-1:0]     valid;
    logic [NS-1:0]     ready;
    logic [DATA_W-1:0] a_q   [NS];
    logic [DATA_W-1:0] b_q   [NS];
    logic [DATA_W-1:0] sum_q [NS];
    logic [NS-1:0]     carry_q;
    logic [1:0]        op_q  [NS];

    logic              is_sub;
    logic [DATA_W-1:0] b_eff;

    assign is_sub = (in_op == OP_SUB) || (in_op == OP_SSUB);
    assign b_eff  = is_sub ? ~in_b : in_b;

    // Stage k can load unless it and every stage after it are full while the output stalls;
    // written as a closed form so the chain has no self-referencing vector.
    for (genvar k = 0; k < NS; k++) begin : g_ready
        assign ready[k] = out_ready || !(&valid[NS-1:k]);
    end

    for (genvar k = 0; k < NS; k++) begin : g_stage
        if (k == 0) begin : g_first
            adder_slice #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .IDX(k)) u_slice (
                .clk(clk_clk), .rst(reset_reset), .load(ready[k]),
                .prev_valid(in_valid), .prev_a(in_a), .prev_b(b_eff), .prev_sum('0),
                .prev_carry(is_sub), .prev_op(in_op),
                .valid(valid[k]), .a(a_q[k]), .b(b_q[k]), .sum(sum_q[k]),
                .carry(carry_q[k]), .op(op_q[k])
            );
        end else begin : g_next
            adder_slice #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .IDX(k)) u_slice (
                .clk(clk_clk), .rst(reset_reset), .load(ready[k]),
                .prev_valid(valid[k-1]), .prev_a(a_q[k-1]), .prev_b(b_q[k-1]), .prev_sum(sum_q[k-1]),
                .prev_carry(carry_q[k-1]), .prev_op(op_q[k-1]),
                .valid(valid[k]), .a(a_q[k]), .b(b_q[k]), .sum(sum_q[k]),
                .carry(carry_q[k]), .op(op_q[k])
            );
        end
    end

    logic a_msb;
    logic b_msb;
    logic s_msb;
    logic is_sat;
    logic unused_low_bits;

    assign a_msb  = a_q[L][DATA_W-1];
    assign b_msb  = b_q[L][DATA_W-1];
    assign s_msb  = sum_q[L][DATA_W-1];
    assign is_sat = (op_q[L] == OP_SADD) || (op_q[L] == OP_SSUB);
    assign unused_low_bits = ^{a_q[L][DATA_W-2:0], b_q[L][DATA_W-2:0]};

    // Flags derive from the final stage register, so they hold with out_sum under backpressure.
    assign in_ready  = ready[0];
    assign out_valid = valid[L];
    assign out_ovf   = (a_msb == b_msb) && (s_msb != a_msb);
    assign out_sum   = (is_sat && out_ovf) ? (a_msb ? SAT_NEG : SAT_POS) : sum_q[L];
    assign out_carry = carry_q[L] ^ op_q[L][0];
    assign out_zero  = valid[L] && (out_sum == '0);
    assign busy      = |valid;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            op_count <= '0;
        end else if (out_valid && out_ready) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipelined_adder_core.sv
// Directed self-checking bench for pipelined_adder_core at default parameters (64-bit, 4 stages).
module tb_pipelined_adder_core;
    import adder_pkg::*;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_carry;
    logic        out_ovf;
    logic        out_zero;
    logic [31:0] op_count;
    logic        busy;

    pipelined_adder_core #(.DATA_W(64), .CHUNK_W(16), .CNT_W(32)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero),
        .op_count(op_count), .busy(busy)
    );

    always #5 clk_clk = ~clk_clk;

    int   compared   = 0;
    int   mismatched = 0;
    int   lat;
    int   nacc;
    int   nemit;
    int   stale;
    logic acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one beat at the current cycle and waits (bounded) for out_valid;
    // lat counts clock edges starting with the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        lat = 0;
        do begin
            @(posedge clk_clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    initial begin
        reset_reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = OP_ADD; out_ready = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1 reset_reset = 1'b0;
        @(negedge clk_clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_op_count", op_count, 0);
        check("rst_busy", busy, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_flags", {out_carry, out_ovf, out_zero}, 0);

        // ADD wrap to zero
        @(posedge clk_clk); #1;
        out_ready = 1'b1;
        issue(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check("add_latency", lat, 4);
        check("add_sum", out_sum, 64'h0);
        check("add_carry", out_carry, 1);
        check("add_zero", out_zero, 1);
        check("add_ovf", out_ovf, 0);
        @(posedge clk_clk); #1;
        check("add_drained", out_valid, 0);

        // SUB with borrow
        issue(OP_SUB, 64'd5, 64'd7);
        check("sub_latency", lat, 4);
        check("sub_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_borrow", out_carry, 1);
        check("sub_ovf", out_ovf, 0);
        check("sub_zero", out_zero, 0);
        @(posedge clk_clk); #1;

        // Saturation, two back-to-back beats
        in_valid = 1'b1; in_a = 64'h7FFF_FFFF_FFFF_FFFF; in_b = 64'd1; in_op = OP_SADD;
        @(posedge clk_clk); #1;
        in_a = 64'h8000_0000_0000_0000; in_b = 64'd1; in_op = OP_SSUB;
        @(posedge clk_clk); #1;
        in_valid = 1'b0;
        lat = 2;
        while (!out_valid && lat < 20) begin
            @(posedge clk_clk); #1;
            lat++;
        end
        check("sadd_latency", lat, 4);
        check("sadd_sum", out_sum, 64'h7FFF_FFFF_FFFF_FFFF);
        check("sadd_ovf", out_ovf, 1);
        check("sadd_carry", out_carry, 0);
        check("sadd_zero", out_zero, 0);
        @(posedge clk_clk); #1;
        check("ssub_valid", out_valid, 1);
        check("ssub_sum", out_sum, 64'h8000_0000_0000_0000);
        check("ssub_ovf", out_ovf, 1);
        check("ssub_borrow", out_carry, 0);
        @(posedge clk_clk); #1;
        check("four_ops_count", op_count, 4);
        check("idle_busy", busy, 0);

        // Backpressure: fresh reset so op_count starts from zero
        reset_reset = 1'b1;
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;
        out_ready = 1'b0;
        nacc = 0;
        in_valid = 1'b1; in_a = 64'd0; in_b = 64'd0; in_op = OP_ADD;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_clk);
            acc = in_valid && in_ready;
            if (out_valid) begin
                check("hold_sum", out_sum, 64'd0);
                check("hold_zero", out_zero, 1);
            end
            @(posedge clk_clk); #1;
            if (acc) begin
                nacc++;
                if (nacc < 8) begin in_a = 64'(nacc); in_b = 64'(nacc); end
                else in_valid = 1'b0;
            end
        end
        check("stall_accepts", nacc, 4);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_busy", busy, 1);

        out_ready = 1'b1;
        nemit = 0;
        for (int c = 0; c < 40 && nemit < 8; c++) begin
            @(negedge clk_clk);
            acc = in_valid && in_ready;
            if (out_valid) begin
                check("drain_order", out_sum, 64'(2 * nemit));
                nemit++;
            end
            @(posedge clk_clk); #1;
            if (acc) begin
                nacc++;
                if (nacc < 8) begin in_a = 64'(nacc); in_b = 64'(nacc); end
                else in_valid = 1'b0;
            end
        end
        check("drain_emitted", nemit, 8);
        check("drain_accepted", nacc, 8);
        check("drain_op_count", op_count, 8);
        check("drain_busy", busy, 0);

        // Reset with three beats in flight
        in_valid = 1'b1; in_a = 64'd100; in_b = 64'd23; in_op = OP_ADD;
        repeat (3) @(posedge clk_clk);
        #1 in_valid = 1'b0;
        check("inflight_busy", busy, 1);
        check("inflight_no_out", out_valid, 0);
        reset_reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_op_count", op_count, 0);
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_clk); #1;
            if (out_valid) stale++;
        end
        check("no_stale_beats", stale, 0);
        check("post_rst_count", op_count, 0);
        check("post_rst_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
